wb_regfile: RTL and testbench

Writeback-stage register file: the consuming end of the MEM/WB pipeline register. Each cycle it selects the writeback value (ALU result or memory data) from the MEM/WB outputs and commits it to a 32 x 32-bit integer register array. It serves two decode-stage read ports with same-cycle write-through bypass, plus one debug read port. It also keeps a committed-write counter for performance monitoring.

---
 rtl/wb_regfile.sv | 68 ++++++
 tb/tb_wb_regfile.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage integer register file: selects ALU or load data, commits it,
// serves two bypassed decode read ports, a registered debug port and a write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_aluOut_WB_memOut,
  input  logic              wb_writeReg,
  input  logic [DATA_W-1:0] wb_outMem,
  input  logic [DATA_W-1:0] wb_outAlu,
  input  logic [4:0]        wb_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  output logic [DATA_W-1:0] id_rdata1,
  output logic [DATA_W-1:0] id_rdata2,
  output logic [DATA_W-1:0] wb_writeData,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              commit;

  assign wb_writeData = wb_aluOut_WB_memOut ? wb_outMem : wb_outAlu;
  assign commit       = wb_writeReg && (wb_rd != 5'd0) && !rst;

  // Bypass lets decode see the value retiring this cycle without a stall.
  always_comb begin
    id_rdata1 = '0;
    if (!rst && id_rs1 != 5'd0) begin
      if (commit && wb_rd == id_rs1) id_rdata1 = wb_writeData;
      else                           id_rdata1 = regs[id_rs1];
    end
  end

  always_comb begin
    id_rdata2 = '0;
    if (!rst && id_rs2 != 5'd0) begin
      if (commit && wb_rd == id_rs2) id_rdata2 = wb_writeData;
      else                           id_rdata2 = regs[id_rs2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wb_rd] <= wb_writeData;
    end
  end

  // Debug view samples the array before this edge's commit lands.
  always_ff @(posedge clk) begin
    if (rst)                   dbg_data <= '0;
    else if (dbg_addr == 5'd0) dbg_data <= '0;
    else                       dbg_data <= regs[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (rst)         wr_count <= '0;
    else if (commit) wr_count <= wr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_aluOut_WB_memOut;
  logic        wb_writeReg;
  logic [31:0] wb_outMem;
  logic [31:0] wb_outAlu;
  logic [4:0]  wb_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] id_rdata1;
  logic [31:0] id_rdata2;
  logic [31:0] wb_writeData;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [3:0]  wr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [31:0] mdbg;
  int unsigned mcnt;

  wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb_aluOut_WB_memOut(wb_aluOut_WB_memOut), .wb_writeReg(wb_writeReg),
    .wb_outMem(wb_outMem), .wb_outAlu(wb_outAlu), .wb_rd(wb_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .wb_writeData(wb_writeData),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] rs, input logic [31:0] wd,
                                             input bit wr);
    if (rst || rs == 5'd0) return 32'd0;
    if (wr && wb_rd == rs) return wd;
    return mregs[rs];
  endfunction

  task automatic drive(input bit r, input bit sel, input bit we, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] da);
    rst = r; wb_aluOut_WB_memOut = sel; wb_writeReg = we;
    wb_outMem = mem; wb_outAlu = alu; wb_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; dbg_addr = da;
  endtask

  // Inputs are driven at posedge+1; combinational checks at posedge+3, state at next posedge+1.
  task automatic run_cycle();
    logic [31:0] wd;
    bit          wr;
    #2;
    wd = wb_aluOut_WB_memOut ? wb_outMem : wb_outAlu;
    wr = wb_writeReg && wb_rd != 5'd0 && !rst;
    chk("wdata", wb_writeData, wd);
    chk("rdata1", id_rdata1, model_read(id_rs1, wd, wr));
    chk("rdata2", id_rdata2, model_read(id_rs2, wd, wr));
    @(posedge clk);
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 32'd0;
      mdbg = 32'd0;
      mcnt = 0;
    end else begin
      mdbg = (dbg_addr == 5'd0) ? 32'd0 : mregs[dbg_addr];
      if (wr) begin
        mregs[wb_rd] = wd;
        mcnt = (mcnt + 1) % 16;
      end
    end
    #1;
    chk("dbg", dbg_data, mdbg);
    chk("count", 32'(wr_count), 32'(mcnt));
  endtask

  initial begin
    foreach (mregs[i]) mregs[i] = 32'd0;
    mdbg = 32'd0;
    mcnt = 0;

    // reset, then write DEADBEEF to x5 (bypass), read from array, reset with a write presented
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);                        run_cycle();
    drive(0, 0, 1, 0, 32'hDEADBEEF, 5, 5, 0, 5);             run_cycle();
    drive(0, 0, 0, 0, 0, 0, 5, 5, 5);                        run_cycle();
    chk("x5_committed", id_rdata1, 32'hDEADBEEF);
    drive(1, 0, 1, 0, 32'hCAFEF00D, 5, 5, 5, 5);             run_cycle();
    drive(0, 0, 0, 0, 0, 0, 5, 5, 5);                        run_cycle();
    chk("x5_after_rst", id_rdata1, 32'd0);

    // mux select and commit
    drive(0, 0, 1, 32'h22, 32'h11, 3, 0, 0, 0);              run_cycle();
    drive(0, 1, 1, 32'h22, 32'h11, 4, 3, 4, 3);              run_cycle();
    drive(0, 0, 0, 0, 0, 0, 3, 4, 4);                        run_cycle();
    chk("x3_alu", id_rdata1, 32'h11);
    chk("x4_mem", id_rdata2, 32'h22);
    chk("count_two", 32'(wr_count), 32'd2);

    // x0 stays zero and does not count
    drive(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);             run_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                        run_cycle();

    // bypass on both ports, then same cycle without write enable
    drive(0, 0, 1, 0, 32'h77, 7, 0, 0, 0);                   run_cycle();
    drive(0, 0, 0, 0, 32'hA5A5A5A5, 7, 7, 7, 7);             run_cycle();
    drive(0, 0, 1, 0, 32'hA5A5A5A5, 7, 7, 7, 7);             run_cycle();

    // debug latency on x9
    drive(0, 0, 1, 0, 32'h99, 9, 0, 0, 9);                   run_cycle();
    drive(0, 0, 1, 0, 32'h1234, 9, 0, 0, 9);                 run_cycle();
    chk("dbg_old_x9", dbg_data, 32'h99);
    drive(0, 0, 0, 0, 0, 0, 9, 0, 9);                        run_cycle();
    chk("dbg_new_x9", dbg_data, 32'h1234);

    // counter wrap: 17 commits after reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);                        run_cycle();
    for (int i = 0; i < 17; i++) begin
      drive(0, i[0], 1, $urandom, $urandom, 5'(1 + (i % 31)), 5'(i), 5'(i + 1), 5'(i));
      run_cycle();
    end
    chk("count_wrap", 32'(wr_count), 32'd1);

    // randomized traffic over a small register window to exercise the bypass
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
